// File: rtl/uart_frame_tx_pkg.sv
// uart_frame_tx_pkg
//   Shared definitions for the 8-byte UART command/status frame: frame
//   geometry, status header value, FSM state encodings and the additive
//   checksum used by both the transmitter and the frame receiver.
package uart_frame_tx_pkg;

   localparam int         FRAME_BYTES   = 8;
   localparam int         PAYLOAD_BYTES = FRAME_BYTES - 1;
   localparam logic [7:0] HDR_STATUS    = 8'h07;

   typedef enum logic [2:0] {
      FRM_IDLE,
      FRM_LOAD,
      FRM_SEND,
      FRM_WAIT,
      FRM_DONE
   } frm_state_t;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_START,
      SER_DATA,
      SER_STOP
   } ser_state_t;

   // 8-bit wrapping sum of the seven payload bytes; carries are discarded.
   function automatic logic [7:0] frame_checksum(input logic [8*PAYLOAD_BYTES-1:0] payload);
      logic [7:0] sum;
      sum = 8'h00;
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
         sum = sum + payload[8*k +: 8];
      end
      return sum;
   endfunction

endpackage

// File: rtl/uart_frame_tx_byte.sv
// uart_byte_tx
//   8N1 byte serialiser. A one-cycle pi_flag in idle loads pi_data and sends
//   start bit, 8 data bits LSB first, stop bit; each bit lasts BAUD_CNT_MAX
//   clocks. tx is registered.
//   Ports:
//     sys_clk, sys_rst_n   clock, async active-low reset
//     pi_data[7:0]         byte to send (sampled with pi_flag)
//     pi_flag              load strobe, honoured only when idle
//     busy                 serialiser not idle
//     done                 high in the last clock of the stop bit
//     tx                   serial line, idles high
//
//   state     | meaning
//   SER_IDLE  | line high, waiting for pi_flag
//   SER_START | driving start bit (0)
//   SER_DATA  | driving data bit r_bit_idx
//   SER_STOP  | driving stop bit (1)
module uart_byte_tx
   import uart_frame_tx_pkg::*;
#(
   parameter int unsigned BAUD_CNT_MAX = 5208
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] pi_data,
   input  logic       pi_flag,
   output logic       busy,
   output logic       done,
   output logic       tx
);

   localparam int unsigned CW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

   ser_state_t    r_state;
   ser_state_t    w_state_nxt;
   logic [CW-1:0] r_baud_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          w_baud_wrap;
   logic          w_tx_nxt;

   assign w_baud_wrap = (r_baud_cnt == CW'(BAUD_CNT_MAX - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= SER_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tx_nxt    = 1'b1;
      unique case (r_state)
         SER_IDLE:  if (pi_flag) w_state_nxt = SER_START;
         SER_START: if (w_baud_wrap) w_state_nxt = SER_DATA;
         SER_DATA:  if (w_baud_wrap && (r_bit_idx == 3'd7)) w_state_nxt = SER_STOP;
         SER_STOP:  if (w_baud_wrap) w_state_nxt = SER_IDLE;
         default:   w_state_nxt = SER_IDLE;
      endcase
      // The shifter moves at the same edge tx updates, so when staying in
      // DATA across a wrap the next bit is still at r_shift[1].
      case (w_state_nxt)
         SER_START: w_tx_nxt = 1'b0;
         SER_DATA:  w_tx_nxt = (r_state == SER_DATA && w_baud_wrap) ? r_shift[1] : r_shift[0];
         default:   w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
      end else begin
         r_tx <= w_tx_nxt;
         if (r_state == SER_IDLE || w_baud_wrap) r_baud_cnt <= '0;
         else                                    r_baud_cnt <= r_baud_cnt + CW'(1);
         if (r_state == SER_IDLE && pi_flag) r_shift <= pi_data;
         else if (r_state == SER_DATA && w_baud_wrap) r_shift <= {1'b0, r_shift[7:1]};
         if (r_state == SER_DATA && w_baud_wrap) r_bit_idx <= r_bit_idx + 3'd1;
      end
   end

   assign busy = (r_state != SER_IDLE);
   assign done = (r_state == SER_STOP) && w_baud_wrap;
   assign tx   = r_tx;

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   Frame transmitter: latches a 7-byte payload, appends the additive
//   checksum as byte 7 and sends all 8 bytes back-to-back as 8N1.
//   Ports:
//     sys_clk, sys_rst_n   clock, async active-low reset
//     tx_start             one-cycle send request (ignored while tx_busy)
//     tx_frame[55:0]       payload, byte k at [8k+7:8k], byte 0 sent first
//     tx_busy              frame in progress
//     tx_done              one-cycle pulse after the last stop bit
//     tx                   serial line, idles high
//
//   state    | meaning
//   FRM_IDLE | waiting for tx_start
//   FRM_LOAD | checksum into buffer byte 7, byte index cleared
//   FRM_SEND | strobe buffer[byte_idx] into the serialiser
//   FRM_WAIT | waiting for serialiser done
//   FRM_DONE | tx_done pulse; a new tx_start is accepted here too
module uart_frame_tx
   import uart_frame_tx_pkg::*;
#(
   parameter  int unsigned UART_BPS     = 9600,
   parameter  int unsigned CLK_FREQ     = 50_000_000,
   localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        tx_start,
   input  logic [55:0] tx_frame,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        tx
);

   localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

   frm_state_t  r_state;
   frm_state_t  w_state_nxt;
   logic [63:0] r_buf;
   logic [2:0]  r_byte_idx;
   logic        r_tx_busy;
   logic        r_tx_done;
   logic        w_accept;
   logic        w_ser_flag;
   logic        w_ser_busy;
   logic        w_ser_done;
   logic        w_ser_tx;
   logic [7:0]  w_ser_data;

   // tx_busy is already low in DONE, so a request there is a fresh acceptance.
   assign w_accept   = tx_start && (r_state == FRM_IDLE || r_state == FRM_DONE);
   assign w_ser_data = r_buf[{r_byte_idx, 3'b000} +: 8];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= FRM_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ser_flag  = 1'b0;
      unique case (r_state)
         FRM_IDLE: if (w_accept) w_state_nxt = FRM_LOAD;
         FRM_LOAD: w_state_nxt = FRM_SEND;
         FRM_SEND: begin
            if (!w_ser_busy) begin
               w_ser_flag  = 1'b1;
               w_state_nxt = FRM_WAIT;
            end
         end
         FRM_WAIT: begin
            if (w_ser_done) w_state_nxt = (r_byte_idx == LAST_IDX) ? FRM_DONE : FRM_SEND;
         end
         FRM_DONE: w_state_nxt = w_accept ? FRM_LOAD : FRM_IDLE;
         default:  w_state_nxt = FRM_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_buf      <= '0;
         r_byte_idx <= '0;
         r_tx_busy  <= 1'b0;
         r_tx_done  <= 1'b0;
      end else begin
         if (w_accept)                   r_buf        <= {8'h00, tx_frame};
         else if (r_state == FRM_LOAD)   r_buf[63:56] <= frame_checksum(r_buf[55:0]);
         if (r_state == FRM_LOAD) begin
            r_byte_idx <= '0;
         end else if (r_state == FRM_WAIT && w_ser_done && r_byte_idx != LAST_IDX) begin
            r_byte_idx <= r_byte_idx + 3'd1;
         end
         // Status outputs registered from next state so they never glitch.
         r_tx_busy <= (w_state_nxt == FRM_LOAD) || (w_state_nxt == FRM_SEND) ||
                      (w_state_nxt == FRM_WAIT);
         r_tx_done <= (w_state_nxt == FRM_DONE);
      end
   end

   uart_byte_tx #(
      .BAUD_CNT_MAX(BAUD_CNT_MAX)
   ) u_byte_tx (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .pi_data  (w_ser_data),
      .pi_flag  (w_ser_flag),
      .busy     (w_ser_busy),
      .done     (w_ser_done),
      .tx       (w_ser_tx)
   );

   assign tx_busy = r_tx_busy;
   assign tx_done = r_tx_done;
   assign tx      = w_ser_tx;

endmodule
